// File: rtl/mem_responder.sv
// Memory-side responder for the multi-cycle CPU's unified port: accepts one
// word read/write at a time, inserts WAIT_CYCLES wait states, then pulses a response.
module mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_responder: WAIT_CYCLES must be within 0..15");
    end
    if ((1 << IDX_W) != DEPTH_WORDS || ADDR_W <= IDX_W + 2) begin : g_bad_depth
        $error("mem_responder: DEPTH_WORDS must be a power of two addressable by ADDR_W");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic              accept;
    logic              enter_resp;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_write;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_err;
    logic [IDX_W-1:0]  cur_idx;

    // With zero wait states the commit happens on the accept edge itself,
    // so the live request is used in IDLE and the latched copy otherwise.
    always_comb begin
        accept    = req_valid && (state_q == S_IDLE);
        cur_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
        cur_write = (state_q == S_IDLE) ? req_write : write_q;
        cur_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
        cur_err   = (|cur_addr[1:0]) || (|cur_addr[ADDR_W-1:IDX_W+2]);
        cur_idx   = cur_addr[IDX_W+1:2];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= req_addr;
                write_q <= req_write;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                err_q   <= cur_err;
                rdata_q <= (!cur_write && !cur_err) ? mem[cur_idx] : '0;
            end
        end
    end

    // Storage is deliberately not reset; rstn gates the write so a request
    // seen while reset is held can never commit.
    always_ff @(posedge clk) begin
        if (rstn && enter_resp && cur_write && !cur_err) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (2, 0 and 15 wait states) driven
// with directed and random requests, checked against an array memory model.
module tb_mem_responder;

    logic        clk;
    logic        rstn;
    logic        rv  [3];
    logic        rw  [3];
    logic [31:0] ra  [3];
    logic [31:0] rwd [3];
    logic        rdy [3];
    logic        vld [3];
    logic [31:0] rd  [3];
    logic        er  [3];
    logic        bz  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256),
            .WAIT_CYCLES(g == 0 ? 2 : (g == 1 ? 0 : 15))
        ) u_dut (
            .clk(clk), .rstn(rstn),
            .req_valid(rv[g]), .req_write(rw[g]), .req_addr(ra[g]), .req_wdata(rwd[g]),
            .req_ready(rdy[g]), .resp_valid(vld[g]), .resp_rdata(rd[g]),
            .resp_err(er[g]), .busy(bz[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_err = 0;
    int          n_chk = 0;
    logic [31:0] mdl [3][256];

    function automatic int wc(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 0 : 15);
    endfunction

    function automatic logic addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= 256);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request on instance i; returns the response and its latency in cycles.
    task automatic xact(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] o_rd, output logic o_er, output int lat, output int rdy_bad);
        int guard;
        lat = -1; rdy_bad = 0; o_rd = '0; o_er = 1'b0; guard = 0;
        @(negedge clk);
        while (!rdy[i] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        rv[i] = 1'b1; rw[i] = w; ra[i] = a; rwd[i] = d;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                rv[i] = 1'b0; ra[i] = $urandom; rwd[i] = $urandom; rw[i] = ~w;
            end
            if (rdy[i]) rdy_bad++;
            if (vld[i]) begin
                lat  = k;
                o_rd = rd[i];
                o_er = er[i];
                break;
            end
        end
    endtask

    task automatic run(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input string tag);
        logic        e_err;
        logic [31:0] e_rd;
        logic [31:0] o_rd;
        logic        o_er;
        int          lat;
        int          rb;
        e_err = addr_bad(a);
        e_rd  = (!w && !e_err) ? mdl[i][a[9:2]] : 32'd0;
        xact(i, w, a, d, o_rd, o_er, lat, rb);
        chk({tag, " latency"}, 32'(lat), 32'(wc(i) + 1));
        chk({tag, " ready_low"}, 32'(rb), 32'd0);
        chk({tag, " err"}, 32'(o_er), 32'(e_err));
        chk({tag, " rdata"}, o_rd, e_rd);
        if (w && !e_err) mdl[i][a[9:2]] = d;
    endtask

    initial begin
        int          bad_v;
        int          bad_b;
        int          r;
        logic        w;
        logic [31:0] a;
        logic [31:0] ha [8];
        int          acc_t [$];
        int          rsp_t [$];
        logic [31:0] rsp_d [$];

        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rwd[i] = '0;
        end
        #3;
        for (int i = 0; i < 3; i++) begin
            chk("reset resp_valid", 32'(vld[i]), 32'd0);
            chk("reset busy", 32'(bz[i]), 32'd0);
            chk("reset req_ready", 32'(rdy[i]), 32'd1);
            chk("reset rdata", rd[i], 32'd0);
            chk("reset err", 32'(er[i]), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        bad_v = 0; bad_b = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (vld[i]) bad_v++;
                if (bz[i]) bad_b++;
            end
        end
        chk("idle resp_valid", 32'(bad_v), 32'd0);
        chk("idle busy", 32'(bad_b), 32'd0);

        // Fill the 2-wait instance so every later read has a known expectation.
        for (int k = 0; k < 256; k++) run(0, 1'b1, 32'(k * 4), $urandom, "fill");

        run(0, 1'b1, 32'h10, 32'hDEADBEEF, "wr 0x10");
        run(0, 1'b0, 32'h10, 32'h0, "rd 0x10");
        chk("rd 0x10 literal", mdl[0][4], 32'hDEADBEEF);
        run(0, 1'b0, 32'h12, 32'h0, "rd misaligned");
        run(0, 1'b1, 32'h400, 32'hA5A5A5A5, "wr out of range");
        run(0, 1'b1, 32'h3FE, 32'h5A5A5A5A, "wr misaligned");
        run(0, 1'b0, 32'h0, 32'h0, "rd 0x0");
        run(0, 1'b0, 32'h3FC, 32'h0, "rd 0x3FC");

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            if (r < 7)       a = 32'($urandom_range(0, 255)) * 4;
            else if (r == 7) a = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
            else             a = ($urandom | 32'h400) & 32'hFFFF_FFFC;
            run(0, w, a, $urandom, "random");
        end

        run(1, 1'b1, 32'h40, 32'hCAFEF00D, "w0 wr");
        run(1, 1'b0, 32'h40, 32'h0, "w0 rd");
        run(1, 1'b0, 32'h41, 32'h0, "w0 rd misaligned");
        run(2, 1'b1, 32'h80, 32'h0BADF00D, "w15 wr");
        run(2, 1'b0, 32'h80, 32'h0, "w15 rd");

        // Request held valid while the address keeps changing.
        for (int t = 0; t < 8; t++) ha[t] = 32'($urandom_range(0, 255)) * 4;
        @(negedge clk);
        for (int t = 0; t < 8; t++) begin
            if (t > 0) @(negedge clk);
            if (vld[0]) begin
                rsp_t.push_back(t);
                rsp_d.push_back(rd[0]);
            end
            rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = ha[t];
            if (rdy[0]) acc_t.push_back(t);
        end
        @(negedge clk);
        rv[0] = 1'b0;
        chk("held accept count", 32'(acc_t.size()), 32'd2);
        chk("held accept 1 time", 32'((acc_t.size() > 0) ? acc_t[0] : -1), 32'd0);
        chk("held accept 2 time", 32'((acc_t.size() > 1) ? acc_t[1] : -1), 32'd4);
        chk("held resp count", 32'(rsp_t.size()), 32'd2);
        chk("held resp 1 time", 32'((rsp_t.size() > 0) ? rsp_t[0] : -1), 32'd3);
        chk("held resp 1 data", (rsp_d.size() > 0) ? rsp_d[0] : 32'hXXXX_XXXX, mdl[0][ha[0][9:2]]);
        chk("held resp 2 data", (rsp_d.size() > 1) ? rsp_d[1] : 32'hXXXX_XXXX, mdl[0][ha[4][9:2]]);

        // Reset pulse while a write is waiting: it must never commit.
        @(negedge clk);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h20; rwd[0] = 32'h12345678;
        @(negedge clk);
        rv[0] = 1'b0;
        chk("midwait busy before", 32'(bz[0]), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("midwait busy", 32'(bz[0]), 32'd0);
        chk("midwait req_ready", 32'(rdy[0]), 32'd1);
        chk("midwait resp_valid", 32'(vld[0]), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        bad_v = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (vld[0]) bad_v++;
        end
        chk("midwait no response", 32'(bad_v), 32'd0);
        run(0, 1'b0, 32'h20, 32'h0, "rd after abort");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle CPU's unified instruction/data port.
- The CPU's control FSM initiates word reads (fetch or lw) and word writes (sw). This block accepts one request at a time through a valid/ready handshake.
- It holds each request for a programmable number of wait states, then returns a single-cycle response pulse carrying read data or an error flag.
- It contains the word-addressed storage array, so the CPU can be run against realistic, non-zero memory latency.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 32, byte-address width in bits.
- DEPTH_WORDS, 256, number of words in the storage array (power of two).
- WAIT_CYCLES, 2, number of wait-state cycles between request acceptance and response (legal range 0..15).

Ports:
- clk  in  1  system clock; everything samples on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  the CPU presents a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; must be word aligned.
- req_wdata  in  DATA_W  write data.
- req_ready  out  1  high only in IDLE; the request is accepted on an edge where req_valid && req_ready.
- resp_valid  out  1  one-cycle pulse that completes the accepted request.
- resp_rdata  out  DATA_W  read data; valid while resp_valid is high.
- resp_err  out  1  error flag; valid while resp_valid is high.
- busy  out  1  high in WAIT or RESP.

Behaviour:
- Reset (rstn low, asynchronous):
  - state goes to IDLE and the wait counter clears.
  - resp_valid=0, resp_err=0, resp_rdata=0, busy=0, req_ready=1 once state is IDLE.
  - Storage contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an accept edge, latch addr, write and wdata and compute err.
  - If WAIT_CYCLES=0, go to RESP; otherwise load cnt=WAIT_CYCLES-1 and go to WAIT.
  - With no request, stay in IDLE.
- WAIT:
  - req_ready=0; the CPU's inputs are ignored because the latched copies are used.
  - If cnt=0, go to RESP; otherwise decrement cnt.
- Commit and read on entering RESP, i.e. the edge into RESP:
  - A write without error writes mem[addr[ADDR_W-1:2]].
  - A read without error registers mem[index] into resp_rdata.
  - A read with an error, or any write, sets resp_rdata=0.
- RESP:
  - resp_valid=1 for exactly one cycle, then go to IDLE unconditionally.
  - req_ready stays 0 in RESP; a new request is accepted no earlier than the cycle after the resp_valid cycle.
- Latency: request accepted at edge E0 means resp_valid is high in the cycle beginning at edge E0+WAIT_CYCLES+1.
- Back-to-back throughput: one request per WAIT_CYCLES+2 cycles.
- Error (resp_err=1) when either of these holds:
  - addr[1:0] != 0;
  - addr[ADDR_W-1:2] >= DEPTH_WORDS (no wrap-around, no aliasing).
  - An errored write leaves storage unchanged.
- Output hold rules:
  - resp_rdata and resp_err hold their last values after the pulse until the next response or reset.
  - Consumers qualify them with resp_valid only.
- Reset mid-operation:
  - Reset asserted in WAIT aborts the request; no write commits and no response is issued.
  - Reset asserted in RESP drops resp_valid immediately; a write that was already committed stays committed.
- Read-after-write: a read accepted after a write's response returns the newly written data.
- Request changes: changes on req_* while not in IDLE have no effect.
- WAIT_CYCLES outside 0..15 is an elaboration-time error (assertion).

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - write addr 0x10, data 0xDEADBEEF accepted at E0 -> resp_valid pulse in the cycle after E0+3, resp_err=0.
  - read 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0.
- WAIT_CYCLES=0 and 15:
  - read accepted at E0 -> resp_valid exactly 1 and 16 cycles later respectively.
  - req_ready low from the accept edge until after the pulse.
- Errors:
  - read 0x12 (misaligned) -> resp_err=1, resp_rdata=0.
  - write 0x400 with DEPTH_WORDS=256 -> resp_err=1.
  - read of the words previously at 0x0 and 0x3FC -> contents unchanged.
- Held request: req_valid held high with changing addr during WAIT -> only the first request is served; the second request is accepted in IDLE 4 cycles after the first accept (WAIT_CYCLES=2).
- Reset mid-WAIT:
  - write 0x20, data 0x12345678; pulse rstn low during WAIT -> no resp_valid, busy=0, req_ready=1.
  - subsequent read of 0x20 -> the prior value, not 0x12345678.
- Idle stability: req_valid low for 20 cycles after reset -> resp_valid never asserts, busy=0 throughout.
